// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// wait-state counter width, default address width and the access check.
package dm_responder_pkg;

    localparam int DM_ADDR_W = 10;
    localparam int DM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

    // An access is rejected when it is not word aligned or when any byte
    // address bit above the implemented word index is set.
    function automatic logic dm_addr_err(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Byte-lane merge for partial writes: lanes with i_be[n]=1 take the new
// byte, all other lanes keep the old word's byte.
module dm_byte_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_be,
    output logic [31:0] o_word
);

    // Start from the old word and overwrite the enabled lanes.
    always_comb begin
        o_word = i_old;
        for (int n = 0; n < 4; n++) begin
            if (i_be[n]) begin
                o_word[8*n +: 8] = i_new[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the M stage: accepts one word
// request at a time, waits LAT cycles, then acks with read data or an
// error flag. obusy stalls the pipeline while a request is outstanding.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic        iwe,
    input  logic [31:0] iaddr,
    input  logic [3:0]  ibe,
    input  logic [31:0] iwdata,
    output logic        oack,
    output logic [31:0] ordata,
    output logic        oerr,
    output logic        obusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    dm_state_t             r_state;
    dm_state_t             w_next;
    logic [DM_CNT_W-1:0]   r_cnt;

    logic                  r_we;
    logic [31:0]           r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;

    logic                  r_oack;
    logic                  r_oerr;
    logic [31:0]           r_ordata;

    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_acc_we;
    logic [31:0]           w_acc_addr;
    logic                  w_acc_err;
    logic [ADDR_W-1:0]     w_acc_idx;
    logic [ADDR_W-1:0]     w_resp_idx;
    logic                  w_resp_err;
    logic                  w_do_write;
    logic [31:0]           w_merged;

    assign w_accept = (r_state == ST_IDLE) && ireq;

    // The access that lands in RESP next cycle comes straight from the
    // ports when LAT=0 (accept goes directly to RESP), else from the latches.
    assign w_acc_we   = w_accept ? iwe   : r_we;
    assign w_acc_addr = w_accept ? iaddr : r_addr;
    assign w_acc_err  = dm_addr_err(w_acc_addr, ADDR_W);
    assign w_acc_idx  = w_acc_addr[ADDR_W+1:2];

    assign w_resp_idx = r_addr[ADDR_W+1:2];
    assign w_resp_err = dm_addr_err(r_addr, ADDR_W);
    assign w_do_write = (r_state == ST_RESP) && r_we && !w_resp_err;

    dm_byte_merge u_merge (
        .i_old  (r_mem[w_resp_idx]),
        .i_new  (r_wdata),
        .i_be   (r_be),
        .o_word (w_merged)
    );

    // Next-state decode and the combinational stall request.
    always_comb begin
        w_next = r_state;
        obusy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ireq) begin
                    obusy  = 1'b1;
                    w_next = (LAT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                obusy = 1'b1;
                if (r_cnt == DM_CNT_W'(1)) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_next == ST_RESP);

    // State register, wait-state counter and request latches.
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= DM_CNT_W'(LAT);
                r_we    <= iwe;
                r_addr  <= iaddr;
                r_be    <= ibe;
                r_wdata <= iwdata;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - DM_CNT_W'(1);
            end
        end
    end

    // Response registers, loaded on the edge that enters RESP so the
    // read data, ack and error all appear together for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_oack   <= 1'b0;
            r_oerr   <= 1'b0;
            r_ordata <= '0;
        end else begin
            r_oack   <= w_enter_resp;
            r_oerr   <= w_enter_resp && w_acc_err;
            r_ordata <= (w_enter_resp && !w_acc_we && !w_acc_err) ? r_mem[w_acc_idx] : '0;
        end
    end

    // Memory array; the write commits at the end of the RESP cycle.
    // NOTE: the array is reset because every word must read 0 after reset;
    // this maps it to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_write) begin
            r_mem[w_resp_idx] <= w_merged;
        end
    end

    assign oack   = r_oack;
    assign oerr   = r_oerr;
    assign ordata = r_ordata;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a LAT=2 instance driven from a
// vector table plus hand sequences, and a LAT=0 instance for back-to-back.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic        ireq;
    logic        ireq0;
    logic        iwe;
    logic [31:0] iaddr;
    logic [3:0]  ibe;
    logic [31:0] iwdata;
    logic        oack,  oerr,  obusy;
    logic [31:0] ordata;
    logic        oack0, oerr0, obusy0;
    logic [31:0] ordata0;

    int n_cmp  = 0;
    int n_fail = 0;

    dm_responder #(.ADDR_W(10), .LAT(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireq   (ireq),
        .iwe    (iwe),
        .iaddr  (iaddr),
        .ibe    (ibe),
        .iwdata (iwdata),
        .oack   (oack),
        .ordata (ordata),
        .oerr   (oerr),
        .obusy  (obusy)
    );

    dm_responder #(.ADDR_W(10), .LAT(0)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .ireq   (ireq0),
        .iwe    (iwe),
        .iaddr  (iaddr),
        .ibe    (ibe),
        .iwdata (iwdata),
        .oack   (oack0),
        .ordata (ordata0),
        .oerr   (oerr0),
        .obusy  (obusy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the LAT=2 instance; starts and ends just after a
    // falling edge with the DUT idle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input string tag,
                           output int lat, output logic err, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        lat = 0;
        err = 1'b0;
        rd  = '0;
        ireq = 1'b1; iwe = we; iaddr = addr; ibe = be; iwdata = wd;
        #1;
        check({tag, "_busy_accept"}, 32'(obusy), 32'd1);
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (oack) begin
                got = 1'b1;
                lat = n;
                err = oerr;
                rd  = ordata;
                check({tag, "_busy_resp"}, 32'(obusy), 32'd0);
            end else begin
                check({tag, "_busy_wait"}, 32'(obusy), 32'd1);
            end
        end
        if (!got) begin
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
        end
        ireq = 1'b0;
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(oack), 32'd0);
        check({tag, "_rdata_idle"}, ordata, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic        got;

        reset = 1'b0; ireq = 1'b0; ireq0 = 1'b0;
        iwe = 1'b0; iaddr = '0; ibe = '0; iwdata = '0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF,  1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hAABBCCDD,  1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0020, 4'h5, 32'h11223344,  1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b0, 32'hAA22CC44};
        vecs[6]  = '{1'b1, 32'h0000_0012, 4'hF, 32'h55555555,  1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h99999999,  1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0024, 4'h0, 32'hFFFFFFFF,  1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0011, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h12345678,  1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         1'b0, 32'h12345678};
        vecs[15] = '{1'b0, 32'h0000_1010, 4'hF, 32'h0,         1'b1, 32'h0};

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_oack",   32'(oack),   32'd0);
        check("rst_obusy",  32'(obusy),  32'd0);
        check("rst_ordata", ordata,      32'd0);
        check("rst_oerr",   32'(oerr),   32'd0);
        check("rst_obusy0", 32'(obusy0), 32'd0);

        // Table: latency, error and read data for each request.
        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                    $sformatf("v%0d", i), lat, err, rd);
            check($sformatf("v%0d_lat", i),   32'(lat), 32'd3);
            check($sformatf("v%0d_err", i),   32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i), rd,       vecs[i].exp_rd);
        end

        // Inputs changing and ireq dropping after accept are ignored.
        ireq = 1'b1; iwe = 1'b1; iaddr = 32'h30; ibe = 4'hF; iwdata = 32'h01020304;
        @(negedge clk);
        ireq = 1'b0; iwe = 1'b0; iaddr = 32'h34; ibe = 4'h0; iwdata = 32'hFFFFFFFF;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (oack) begin
                got = 1'b1;
                check("stab_err", 32'(oerr), 32'd0);
            end
        end
        check("stab_acked", 32'(got), 32'd1);
        @(negedge clk);
        run_txn(1'b0, 32'h30, 4'hF, 32'h0, "stab_rd30", lat, err, rd);
        check("stab_rd30_data", rd, 32'h01020304);
        run_txn(1'b0, 32'h34, 4'hF, 32'h0, "stab_rd34", lat, err, rd);
        check("stab_rd34_data", rd, 32'h0);

        // LAT=0 back-to-back with ireq held: write then read.
        ireq0 = 1'b1; iwe = 1'b1; iaddr = 32'h8; ibe = 4'hF; iwdata = 32'hCAFEF00D;
        #1;
        check("b2b_busy_acc1", 32'(obusy0), 32'd1);
        @(negedge clk);
        check("b2b_ack1",      32'(oack0),  32'd1);
        check("b2b_err1",      32'(oerr0),  32'd0);
        check("b2b_busy_rsp1", 32'(obusy0), 32'd0);
        iwe = 1'b0;
        @(negedge clk);
        check("b2b_bubble",    32'(oack0),  32'd0);
        check("b2b_busy_acc2", 32'(obusy0), 32'd1);
        @(negedge clk);
        check("b2b_ack2",      32'(oack0),  32'd1);
        check("b2b_rdata2",    ordata0,     32'hCAFEF00D);
        ireq0 = 1'b0;
        @(negedge clk);
        check("b2b_idle",      32'(oack0),  32'd0);

        // Reset pulsed during the WAIT of a write aborts it.
        ireq = 1'b1; iwe = 1'b1; iaddr = 32'h40; ibe = 4'hF; iwdata = 32'h77777777;
        @(negedge clk);
        check("abort_busy_wait", 32'(obusy), 32'd1);
        reset = 1'b0;
        ireq  = 1'b0;
        got   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (oack) got = 1'b1;
        end
        check("abort_no_ack", 32'(got), 32'd0);
        run_txn(1'b0, 32'h40, 4'hF, 32'h0, "abort_rd40", lat, err, rd);
        check("abort_rd40_data", rd, 32'h0);
        run_txn(1'b0, 32'h10, 4'hF, 32'h0, "abort_rd10", lat, err, rd);
        check("abort_rd10_data", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
